// File: rtl/aq_fcnvt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aq_fcnvt_pkg
// Description : Shared constants and rounding helper for the fcnvt blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package aq_fcnvt_pkg;

  // Rounding-mode encodings; 5..7 are treated as RNE.
  localparam logic [2:0] c_RM_RNE = 3'd0;
  localparam logic [2:0] c_RM_RTZ = 3'd1;
  localparam logic [2:0] c_RM_RDN = 3'd2;
  localparam logic [2:0] c_RM_RUP = 3'd3;
  localparam logic [2:0] c_RM_RMM = 3'd4;

  // Bit positions inside the {NV,DZ,OF,UF,NX} flag vector.
  localparam int c_FF_NX = 0;
  localparam int c_FF_UF = 1;
  localparam int c_FF_OF = 2;
  localparam int c_FF_DZ = 3;
  localparam int c_FF_NV = 4;

  localparam logic [31:0] c_CANON_NAN  = 32'h7FC0_0000;
  localparam logic [31:0] c_MAX_FINITE = 32'h7F7F_FFFF;
  localparam logic [31:0] c_POS_INF    = 32'h7F80_0000;

  // Double-exponent bounds: shifter window low/high edge and last normal.
  localparam logic [10:0] c_EXP_DENORM_LO = 11'd872;
  localparam logic [10:0] c_EXP_DENORM_HI = 11'd896;
  localparam logic [10:0] c_EXP_NORM_HI   = 11'd1150;

  // Decide whether the magnitude is incremented for the given rounding mode.
  function automatic logic round_up(input logic [2:0] rm, input logic s,
                                    input logic g, input logic st, input logic lsb);
    logic r;
    case (rm)
      c_RM_RTZ: r = 1'b0;
      c_RM_RDN: r = s & (g | st);
      c_RM_RUP: r = ~s & (g | st);
      c_RM_RMM: r = g;
      default:  r = g & (st | lsb);
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aq_fcnvt_dtos_d.sv
`default_nettype none
// ============================================================================
// Module      : aq_fcnvt_dtos_d
// Description : Denormal-range shifter. Aligns {1,f} of a double with exponent
//               872..896 to single-denormal units (2^-149); returns the integer
//               part and the shifted-out bits (guard at bit 53). Outside that
//               window it returns v=0, guard 0, sticky 1.
// Revision    : 1.0 - initial release
// ============================================================================
module aq_fcnvt_dtos_d
  import aq_fcnvt_pkg::*;
(
  input  logic [10:0] dtos_cnt_i,
  input  logic [51:0] dtos_src_i,
  output logic [23:0] dtos_v_o,
  output logic [53:0] dtos_x_o
);

  logic [10:0] w_sh;
  logic [77:0] w_shifted;

  // Exponent 896 needs no shift in this frame; each step lower drops one bit.
  assign w_sh      = c_EXP_DENORM_HI - dtos_cnt_i;
  assign w_shifted = {1'b0, 1'b1, dtos_src_i, 24'd0} >> w_sh;

  // Select the aligned result inside the window, else the tiny default.
  always_comb begin
    dtos_v_o = 24'd0;
    dtos_x_o = 54'd1;
    if ((dtos_cnt_i >= c_EXP_DENORM_LO) && (dtos_cnt_i <= c_EXP_DENORM_HI)) begin
      dtos_v_o = w_shifted[77:54];
      dtos_x_o = w_shifted[53:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/aq_fcnvt_dtos_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aq_fcnvt_dtos_ctrl
// Description : Shared fcvt.s.d unit, two round-robin requesters, two-stage
//               pipeline (operand register, then convert into result register).
// Revision    : 1.0 - initial release
// ============================================================================
module aq_fcnvt_dtos_ctrl
  import aq_fcnvt_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst_b,
  input  logic             flush,
  input  logic             req0_vld,
  output logic             req0_rdy,
  input  logic [63:0]      req0_src,
  input  logic [2:0]       req0_rm,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_vld,
  output logic             req1_rdy,
  input  logic [63:0]      req1_src,
  input  logic [2:0]       req1_rm,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic [31:0]      res_data,
  output logic [4:0]       res_fflags,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_id
);

  logic             s1_vld_q, s1_vld_d;
  logic [63:0]      s1_src_q, s1_src_d;
  logic [2:0]       s1_rm_q, s1_rm_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s1_id_q, s1_id_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             res_vld_q, res_vld_d;
  logic [31:0]      res_data_q, res_data_d;
  logic [4:0]       res_fflags_q, res_fflags_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic             res_id_q, res_id_d;

  logic w_s2_go, w_s1_acc, w_win0, w_win1;

  // Handshake and round-robin arbitration; grants depend only on vld and state.
  assign w_s2_go  = s1_vld_q & (~res_vld_q | res_rdy);
  assign w_s1_acc = (~s1_vld_q | w_s2_go) & ~flush;
  assign w_win0   = req0_vld & (~req1_vld | ~rr_ptr_q);
  assign w_win1   = req1_vld & (~req0_vld | rr_ptr_q);
  assign req0_rdy = w_s1_acc & w_win0;
  assign req1_rdy = w_s1_acc & w_win1;

  // ---------------- stage 2 decode / round / pack ----------------
  logic        w_s;
  logic [10:0] w_e;
  logic [51:0] w_f;
  logic [23:0] w_v;
  logic [53:0] w_x;
  logic [7:0]  w_exp_n;
  logic [30:0] w_sum_n;
  logic        w_rup_n, w_rup_d, w_g_d, w_st_d, w_nx_d;
  logic        w_norm, w_ovf, w_tiny;
  logic [23:0] w_v_rnd;
  logic [31:0] w_ovf_data, w_res_data;
  logic [4:0]  w_res_flags;

  assign w_s = s1_src_q[63];
  assign w_e = s1_src_q[62:52];
  assign w_f = s1_src_q[51:0];

  aq_fcnvt_dtos_d u_dtos_d (
    .dtos_cnt_i (w_e),
    .dtos_src_i (w_f),
    .dtos_v_o   (w_v),
    .dtos_x_o   (w_x)
  );

  // Normal path: rebias by -896 (mod 256 equals +128); round carry ripples into exp.
  assign w_exp_n = w_e[7:0] + 8'd128;
  assign w_rup_n = round_up(s1_rm_q, w_s, w_f[28], |w_f[27:0], w_f[29]);
  assign w_sum_n = {w_exp_n, w_f[51:29]} + {30'd0, w_rup_n};
  assign w_norm  = w_e > c_EXP_DENORM_HI;
  assign w_ovf   = (w_e > c_EXP_NORM_HI) | (w_norm & (&w_sum_n[30:23]));

  // Denormal path: a carry into bit 23 yields the minimum normal naturally.
  assign w_g_d   = w_x[53];
  assign w_st_d  = |w_x[52:0];
  assign w_nx_d  = w_g_d | w_st_d;
  assign w_rup_d = round_up(s1_rm_q, w_s, w_g_d, w_st_d, w_v[0]);
  assign w_v_rnd = w_v + {23'd0, w_rup_d};

  // After-rounding tininess: only exp 896 that rounds up to 2^-126 escapes it.
  assign w_tiny = (w_e < c_EXP_DENORM_HI) |
                  ((w_e == c_EXP_DENORM_HI) & ~((&w_f[51:29]) & w_rup_n));

  // Overflow result depends on rounding direction relative to the sign.
  always_comb begin
    w_ovf_data = {w_s, c_POS_INF[30:0]};
    case (s1_rm_q)
      c_RM_RTZ: w_ovf_data = {w_s, c_MAX_FINITE[30:0]};
      c_RM_RDN: w_ovf_data = w_s ? {1'b1, c_POS_INF[30:0]} : c_MAX_FINITE;
      c_RM_RUP: w_ovf_data = w_s ? {1'b1, c_MAX_FINITE[30:0]} : c_POS_INF;
      default:  w_ovf_data = {w_s, c_POS_INF[30:0]};
    endcase
  end

  // Classify the operand and choose result and exception flags.
  always_comb begin
    w_res_data  = 32'd0;
    w_res_flags = 5'd0;
    if ((w_e == 11'h7FF) && (w_f != 52'd0)) begin
      w_res_data           = c_CANON_NAN;
      w_res_flags[c_FF_NV] = ~w_f[51];
    end else if (w_e == 11'h7FF) begin
      w_res_data = {w_s, c_POS_INF[30:0]};
    end else if ((w_e == 11'd0) && (w_f == 52'd0)) begin
      w_res_data = {w_s, 31'd0};
    end else if (w_ovf) begin
      w_res_data           = w_ovf_data;
      w_res_flags[c_FF_OF] = 1'b1;
      w_res_flags[c_FF_NX] = 1'b1;
    end else if (w_norm) begin
      w_res_data           = {w_s, w_sum_n};
      w_res_flags[c_FF_NX] = w_f[28] | (|w_f[27:0]);
    end else begin
      w_res_data           = {w_s, 7'd0, w_v_rnd};
      w_res_flags[c_FF_NX] = w_nx_d;
      w_res_flags[c_FF_UF] = w_nx_d & w_tiny;
    end
    w_res_flags[c_FF_DZ] = 1'b0;
  end

  // Next state for operand stage, result stage and round-robin pointer.
  always_comb begin
    s1_vld_d     = s1_vld_q;
    s1_src_d     = s1_src_q;
    s1_rm_d      = s1_rm_q;
    s1_tag_d     = s1_tag_q;
    s1_id_d      = s1_id_q;
    rr_ptr_d     = rr_ptr_q;
    res_vld_d    = res_vld_q;
    res_data_d   = res_data_q;
    res_fflags_d = res_fflags_q;
    res_tag_d    = res_tag_q;
    res_id_d     = res_id_q;
    if (flush) begin
      s1_vld_d = 1'b0;
    end else if (req0_rdy) begin
      s1_vld_d = 1'b1;
      s1_src_d = req0_src;
      s1_rm_d  = req0_rm;
      s1_tag_d = req0_tag;
      s1_id_d  = 1'b0;
      rr_ptr_d = 1'b1;
    end else if (req1_rdy) begin
      s1_vld_d = 1'b1;
      s1_src_d = req1_src;
      s1_rm_d  = req1_rm;
      s1_tag_d = req1_tag;
      s1_id_d  = 1'b1;
      rr_ptr_d = 1'b0;
    end else if (w_s2_go) begin
      s1_vld_d = 1'b0;
    end
    if (flush) begin
      res_vld_d = 1'b0;
    end else if (w_s2_go) begin
      res_vld_d    = 1'b1;
      res_data_d   = w_res_data;
      res_fflags_d = w_res_flags;
      res_tag_d    = s1_tag_q;
      res_id_d     = s1_id_q;
    end else if (res_rdy) begin
      res_vld_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      s1_vld_q     <= 1'b0;
      s1_src_q     <= 64'd0;
      s1_rm_q      <= 3'd0;
      s1_tag_q     <= '0;
      s1_id_q      <= 1'b0;
      rr_ptr_q     <= 1'b0;
      res_vld_q    <= 1'b0;
      res_data_q   <= 32'd0;
      res_fflags_q <= 5'd0;
      res_tag_q    <= '0;
      res_id_q     <= 1'b0;
    end else begin
      s1_vld_q     <= s1_vld_d;
      s1_src_q     <= s1_src_d;
      s1_rm_q      <= s1_rm_d;
      s1_tag_q     <= s1_tag_d;
      s1_id_q      <= s1_id_d;
      rr_ptr_q     <= rr_ptr_d;
      res_vld_q    <= res_vld_d;
      res_data_q   <= res_data_d;
      res_fflags_q <= res_fflags_d;
      res_tag_q    <= res_tag_d;
      res_id_q     <= res_id_d;
    end
  end

  assign res_vld    = res_vld_q;
  assign res_data   = res_data_q;
  assign res_fflags = res_fflags_q;
  assign res_tag    = res_tag_q;
  assign res_id     = res_id_q;

endmodule
`default_nettype wire

// File: tb/tb_aq_fcnvt_dtos_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aq_fcnvt_dtos_ctrl
// Description : Directed vector table plus arbitration, backpressure, reset
//               and flush sequences for aq_fcnvt_dtos_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aq_fcnvt_dtos_ctrl;

  logic        forever_cpuclk = 1'b0;
  logic        cpurst_b = 1'b0;
  logic        flush = 1'b0;
  logic        req0_vld = 1'b0, req1_vld = 1'b0;
  logic        req0_rdy, req1_rdy;
  logic [63:0] req0_src = 64'd0, req1_src = 64'd0;
  logic [2:0]  req0_rm = 3'd0, req1_rm = 3'd0;
  logic [4:0]  req0_tag = 5'd0, req1_tag = 5'd0;
  logic        res_vld;
  logic        res_rdy = 1'b1;
  logic [31:0] res_data;
  logic [4:0]  res_fflags;
  logic [4:0]  res_tag;
  logic        res_id;

  int total = 0;
  int bad   = 0;

  aq_fcnvt_dtos_ctrl #(.TAG_W(5)) dut (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .flush          (flush),
    .req0_vld       (req0_vld),
    .req0_rdy       (req0_rdy),
    .req0_src       (req0_src),
    .req0_rm        (req0_rm),
    .req0_tag       (req0_tag),
    .req1_vld       (req1_vld),
    .req1_rdy       (req1_rdy),
    .req1_src       (req1_src),
    .req1_rm        (req1_rm),
    .req1_tag       (req1_tag),
    .res_vld        (res_vld),
    .res_rdy        (res_rdy),
    .res_data       (res_data),
    .res_fflags     (res_fflags),
    .res_tag        (res_tag),
    .res_id         (res_id)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  typedef struct packed {
    logic [63:0] src;
    logic [2:0]  rm;
    logic [31:0] data;
    logic [4:0]  flags;
  } vec_t;

  typedef struct packed {
    logic        id;
    logic [4:0]  tag;
    logic [31:0] data;
    logic [4:0]  flags;
  } exp_t;

  localparam int NVEC = 27;
  vec_t vt [NVEC];
  exp_t sbq [$];
  logic mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One request on the chosen port; checks grant, 2-cycle latency and payload.
  task automatic issue(input logic id, input logic [63:0] src, input logic [2:0] rm,
                       input logic [4:0] tag, input logic [31:0] ed, input logic [4:0] ef,
                       input string nm);
    int n;
    logic g;
    @(negedge forever_cpuclk);
    if (id) begin req1_vld = 1'b1; req1_src = src; req1_rm = rm; req1_tag = tag; end
    else    begin req0_vld = 1'b1; req0_src = src; req0_rm = rm; req0_tag = tag; end
    #1;
    n = 0;
    g = id ? req1_rdy : req0_rdy;
    while (!g && n < 20) begin
      @(negedge forever_cpuclk); #1;
      g = id ? req1_rdy : req0_rdy;
      n++;
    end
    chk({nm, " rdy"}, {63'd0, g}, 64'd1);
    @(posedge forever_cpuclk); #1;
    req0_vld = 1'b0;
    req1_vld = 1'b0;
    @(negedge forever_cpuclk);
    chk({nm, " vld@N+1"}, {63'd0, res_vld}, 64'd0);
    @(negedge forever_cpuclk);
    chk({nm, " vld@N+2"}, {63'd0, res_vld}, 64'd1);
    chk({nm, " data"},  {32'd0, res_data}, {32'd0, ed});
    chk({nm, " flags"}, {59'd0, res_fflags}, {59'd0, ef});
    chk({nm, " tag"},   {59'd0, res_tag}, {59'd0, tag});
    chk({nm, " id"},    {63'd0, res_id}, {63'd0, id});
  endtask

  // Scoreboard monitor for streaming sections.
  always @(negedge forever_cpuclk) begin
    #2;
    if (mon_en && res_vld && res_rdy) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb unexpected result: got tag %0h id %0d expected none", res_tag, res_id);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb id",    {63'd0, res_id}, {63'd0, e.id});
        chk("sb tag",   {59'd0, res_tag}, {59'd0, e.tag});
        chk("sb data",  {32'd0, res_data}, {32'd0, e.data});
        chk("sb flags", {59'd0, res_fflags}, {59'd0, e.flags});
      end
    end
  end

  initial begin
    logic        exp_ptr;
    logic        stall;
    logic        gnt0, gnt1;
    logic [31:0] snap_data;
    logic [4:0]  snap_tag;
    logic        snap_id;

    vt[0]  = '{64'h3FF0000000000000, 3'd0, 32'h3F800000, 5'h00};
    vt[1]  = '{64'h3800000000000000, 3'd0, 32'h00400000, 5'h00};
    vt[2]  = '{64'h36A0000000000000, 3'd0, 32'h00000001, 5'h00};
    vt[3]  = '{64'h3690000000000000, 3'd0, 32'h00000000, 5'h03};
    vt[4]  = '{64'h3690000000000000, 3'd3, 32'h00000001, 5'h03};
    vt[5]  = '{64'h47F0000000000000, 3'd0, 32'h7F800000, 5'h05};
    vt[6]  = '{64'h47F0000000000000, 3'd1, 32'h7F7FFFFF, 5'h05};
    vt[7]  = '{64'h7FF0000000000001, 3'd0, 32'h7FC00000, 5'h10};
    vt[8]  = '{64'h7FF8000000000000, 3'd0, 32'h7FC00000, 5'h00};
    vt[9]  = '{64'hFFF0000000000000, 3'd0, 32'hFF800000, 5'h00};
    vt[10] = '{64'h8000000000000000, 3'd0, 32'h80000000, 5'h00};
    vt[11] = '{64'h3FF8000000000000, 3'd0, 32'h3FC00000, 5'h00};
    vt[12] = '{64'h3FF0000010000000, 3'd0, 32'h3F800000, 5'h01};
    vt[13] = '{64'h3FF0000010000000, 3'd3, 32'h3F800001, 5'h01};
    vt[14] = '{64'h3FF0000010000000, 3'd4, 32'h3F800001, 5'h01};
    vt[15] = '{64'h3FF0000010000000, 3'd7, 32'h3F800000, 5'h01};
    vt[16] = '{64'hBFF0000010000000, 3'd2, 32'hBF800001, 5'h01};
    vt[17] = '{64'h47EFFFFFFFFFFFFF, 3'd0, 32'h7F800000, 5'h05};
    vt[18] = '{64'h47EFFFFFFFFFFFFF, 3'd1, 32'h7F7FFFFF, 5'h01};
    vt[19] = '{64'h380FFFFFFFFFFFFF, 3'd0, 32'h00800000, 5'h01};
    vt[20] = '{64'h380FFFFFFFFFFFFF, 3'd1, 32'h007FFFFF, 5'h03};
    vt[21] = '{64'h3680000000000000, 3'd3, 32'h00000001, 5'h03};
    vt[22] = '{64'h8000000000000001, 3'd2, 32'h80000001, 5'h03};
    vt[23] = '{64'hC7F0000000000000, 3'd2, 32'hFF800000, 5'h05};
    vt[24] = '{64'hC7F0000000000000, 3'd3, 32'hFF7FFFFF, 5'h05};
    vt[25] = '{64'h3FF0000030000000, 3'd0, 32'h3F800002, 5'h01};
    vt[26] = '{64'h47EFFFFFE0000000, 3'd0, 32'h7F7FFFFF, 5'h00};

    // Reset values.
    #1;
    chk("rst res_vld",    {63'd0, res_vld}, 64'd0);
    chk("rst res_data",   {32'd0, res_data}, 64'd0);
    chk("rst res_fflags", {59'd0, res_fflags}, 64'd0);
    chk("rst res_tag",    {59'd0, res_tag}, 64'd0);
    chk("rst res_id",     {63'd0, res_id}, 64'd0);
    repeat (2) @(negedge forever_cpuclk);
    cpurst_b = 1'b1;

    // Directed conversion table, alternating requester ports.
    for (int i = 0; i < NVEC; i++)
      issue(i[0], vt[i].src, vt[i].rm, i[4:0], vt[i].data, vt[i].flags, $sformatf("vec%0d", i));

    // Reset with an operation in flight: nothing may come out.
    @(negedge forever_cpuclk);
    req0_vld = 1'b1; req0_src = 64'h3FF0000000000000; req0_rm = 3'd0; req0_tag = 5'h07;
    #1 chk("rstmid rdy", {63'd0, req0_rdy}, 64'd1);
    @(posedge forever_cpuclk); #1 req0_vld = 1'b0;
    @(negedge forever_cpuclk);
    cpurst_b = 1'b0;
    #1 chk("rstmid res_vld", {63'd0, res_vld}, 64'd0);
    repeat (2) @(negedge forever_cpuclk);
    cpurst_b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge forever_cpuclk);
      chk("rstmid after", {63'd0, res_vld}, 64'd0);
    end

    // Both requesters streaming; 3-cycle result stall in the middle.
    mon_en = 1'b1;
    exp_ptr = 1'b0;
    req0_src = 64'h3FF0000000000000; req0_rm = 3'd0; req0_tag = 5'h00;
    req1_src = 64'h4000000000000000; req1_rm = 3'd0; req1_tag = 5'h10;
    for (int cyc = 0; cyc < 18; cyc++) begin
      @(negedge forever_cpuclk);
      stall = (cyc >= 8) && (cyc <= 10);
      res_rdy = ~stall;
      req0_vld = 1'b1;
      req1_vld = 1'b1;
      #1;
      gnt0 = req0_rdy;
      gnt1 = req1_rdy;
      if (stall) begin
        chk("stall rdy", {62'd0, gnt1, gnt0}, 64'd0);
        chk("stall res_vld", {63'd0, res_vld}, 64'd1);
        if (cyc == 8) begin
          snap_data = res_data; snap_tag = res_tag; snap_id = res_id;
        end else begin
          chk("stall data", {32'd0, res_data}, {32'd0, snap_data});
          chk("stall tag",  {59'd0, res_tag}, {59'd0, snap_tag});
          chk("stall id",   {63'd0, res_id}, {63'd0, snap_id});
        end
      end else begin
        chk("rr grant", {62'd0, gnt1, gnt0}, exp_ptr ? 64'd2 : 64'd1);
        exp_ptr = ~exp_ptr;
      end
      if (gnt0) sbq.push_back('{1'b0, req0_tag, 32'h3F800000, 5'h00});
      if (gnt1) sbq.push_back('{1'b1, req1_tag, 32'h40000000, 5'h00});
      @(posedge forever_cpuclk); #1;
      if (gnt0) req0_tag = req0_tag + 5'd1;
      if (gnt1) req1_tag = req1_tag + 5'd1;
    end
    @(negedge forever_cpuclk);
    req0_vld = 1'b0; req1_vld = 1'b0; res_rdy = 1'b1;
    repeat (5) @(negedge forever_cpuclk);
    #3 chk("drain remaining", sbq.size(), 64'd0);
    mon_en = 1'b0;

    // Flush with operand and result stages both occupied.
    @(negedge forever_cpuclk);
    res_rdy = 1'b0;
    req0_vld = 1'b1; req0_src = 64'h3FF0000000000000; req0_rm = 3'd0; req0_tag = 5'h1E;
    #1 chk("fl rdy a", {63'd0, req0_rdy}, 64'd1);
    @(posedge forever_cpuclk); #1 req0_tag = 5'h1F;
    @(negedge forever_cpuclk); #1 chk("fl rdy b", {63'd0, req0_rdy}, 64'd1);
    @(posedge forever_cpuclk); #1 req0_vld = 1'b0;
    @(negedge forever_cpuclk);
    chk("fl pre vld", {63'd0, res_vld}, 64'd1);
    chk("fl pre tag", {59'd0, res_tag}, 64'h1E);
    flush = 1'b1; req0_vld = 1'b1; req1_vld = 1'b1;
    #1 chk("fl rdy low", {62'd0, req1_rdy, req0_rdy}, 64'd0);
    @(posedge forever_cpuclk); #1;
    flush = 1'b0; req0_vld = 1'b0; req1_vld = 1'b0; res_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge forever_cpuclk);
      chk("fl post vld", {63'd0, res_vld}, 64'd0);
    end
    issue(1'b0, 64'h3FF0000000000000, 3'd0, 5'h03, 32'h3F800000, 5'h00, "after flush");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/aq_fcnvt_dtos_ctrl.md
Name: aq_fcnvt_dtos_ctrl

Overview:
- Shared fcvt.s.d conversion unit that arbitrates between two requesters (req0 and req1) with round-robin priority.
- Two-stage pipeline: operand register, then decode, shift, round and pack into a registered result.
- Drives one instance of the existing 52-bit denormal-range shifter (aq_fcnvt_dtos_d) for results with double exponent 872..896.
- Sits in vfalu beside the other fcnvt blocks; it feeds the FPU writeback arbiter.

Parameters:
TAG_W, 5, width of the opaque tag carried from request to result

Ports:
forever_cpuclk  input  1  clock
cpurst_b  input  1  asynchronous active-low reset
flush  input  1  kill all in-flight operations
req0_vld  input  1  requester 0 valid
req0_rdy  output  1  requester 0 accepted this cycle
req0_src  input  64  IEEE double operand
req0_rm  input  3  rounding mode (0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM)
req0_tag  input  TAG_W  requester 0 tag
req1_vld/req1_rdy/req1_src/req1_rm/req1_tag  same widths and meanings, requester 1
res_vld  output  1  result valid
res_rdy  input  1  consumer accepts result
res_data  output  32  IEEE single result
res_fflags  output  5  {NV,DZ,OF,UF,NX}; DZ is always 0
res_tag  output  TAG_W  tag of the result
res_id  output  1  requester index of the result

Behaviour:
- Clock and reset: one clock, forever_cpuclk. Reset is asynchronous and active-low on cpurst_b.
- Reset values: s1_vld=0, res_vld=0, rr_ptr=0, res_data=0, res_fflags=0, res_tag=0, res_id=0.
- Handshake: a transfer occurs when reqN_vld && reqN_rdy. A result transfers when res_vld && res_rdy. res_data, res_fflags, res_tag and res_id are held stable while res_vld && !res_rdy.
- Pipeline advance: s2_go = s1_vld && (!res_vld || res_rdy). s1 can accept when !s1_vld || s2_go, and !flush.
- Arbitration:
  - Only one reqN_rdy is high per cycle.
  - If one requester is valid, it wins.
  - If both are valid, the requester equal to rr_ptr wins.
  - rr_ptr is set to (winner^1) on every granted transfer.
  - rdy is only asserted if the s1 accept condition holds. rdy depends on vld of both requesters (no combinational path from rdy to vld is allowed upstream).
- Latency: operand accepted at cycle N gives res_vld at N+2 if there is no backpressure. Throughput is one operation per cycle.
- Stage 2 decode (e = src[62:52], f = src[51:0], s = src[63]):
  - NaN: result 0x7FC00000. NV is set if f[51]==0 (signaling NaN).
  - Inf: result {s,0x7F800000}, no flags.
  - Zero: result {s,31'b0}, no flags.
  - Denormal-range input (e==0): treated as the e<=871 case.
  - Normal range, e in 897..1150: exp = e-896, frac = f[51:29], guard = f[28], sticky = |f[27:0]. A round carry increments exp. exp reaching 255 is overflow.
  - e>=1151: overflow.
  - e<=896: shifter cnt = e, src = f. v = f_v, guard = f_x[53], sticky = |f_x[52:0]. After rounding, result = {s,7'b0,v_rounded[23:0]}. A carry into bit 23 naturally produces the minimum normal 0x00800000.
  - Cases e<=871 use the shifter default output: guard 0, sticky 1.
- Round-up condition:
  - RNE: g&&(st||lsb)
  - RTZ: 0
  - RDN: s&&(g||st)
  - RUP: !s&&(g||st)
  - RMM: g
  - rm values 5..7 behave as RNE.
- Flags:
  - NX = g||st, or overflow.
  - Overflow result: RNE/RMM give inf; RTZ gives max finite 0x7F7FFFFF; RDN gives +max or -inf; RUP gives +inf or -max. Flags OF|NX.
  - UF = NX && tiny. tiny = e<=895, or e==896 && !(f[51:29] all ones && the normal-precision round-up condition holds using guard f[28] and sticky |f[27:0]). Tininess is detected after rounding.
- Flush:
  - s1_vld and res_vld clear on the next edge.
  - Both reqN_rdy are low during the flush cycle.
  - rr_ptr is unchanged.
  - A res_rdy in the flush cycle has no effect on ordering; nothing is emitted after the flush.
- Reset mid-operation: all in-flight operations are discarded, with no output.

Decomposition:
- Shared package aq_fcnvt_pkg holds:
  - rounding-mode constants RNE..RMM
  - fflags bit indices
  - canonical NaN 0x7FC00000 and max finite 0x7F7FFFFF
  - exponent bounds 872, 896, 1150.
- One sub-module: the existing aq_fcnvt_dtos_d shifter, instantiated combinationally in stage 2.
- Arbiter, stage registers and rounding stay in this module.

Test Plan:
- req0 src 0x3FF0000000000000, RNE -> res_data 0x3F800000, fflags 0x00, res_id 0, res_vld 2 cycles after the handshake.
- Denormal range:
  - 0x3800000000000000 -> 0x00400000, flags 0x00.
  - 0x36A0000000000000 -> 0x00000001, flags 0x00.
  - 0x3690000000000000 with RNE -> 0x00000000, flags 0x03.
  - 0x3690000000000000 with RUP -> 0x00000001, flags 0x03.
- 0x47F0000000000000: RNE -> 0x7F800000, flags 0x05; RTZ -> 0x7F7FFFFF, flags 0x05. 0x7FF0000000000001 -> 0x7FC00000, flags 0x10.
- Both requesters valid continuously, res_rdy=1 -> grants alternate 0,1,0,1; res_id and res_tag match issue order.
- res_rdy low for 3 cycles with a stream in flight -> outputs stable, req rdy drops once s1 is full, no loss or duplication after release.
- flush while s1 and the output register are both valid -> res_vld=0 on the next cycle, neither tag ever emitted; the next request completes normally in 2 cycles.
